add_sub_accumulator: RTL and testbench

- Registered front/back stage wrapped around the team's existing N-bit ripple adder-subtractor (carry-in tied to the subtract control).
- Accepts operand/op commands over a valid/ready handshake, drives the combinational adder-subtractor and registers the result with status flags.
- Holds a running accumulator so consecutive operations can chain.
- Sits between the datapath operand sequencer (upstream) and the result writeback (downstream).

---
 rtl/add_sub_accumulator.sv | 119 +++++++++++
 tb/tb_add_sub_accumulator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_accumulator
// Description : Registered wrapper around an N-bit ripple adder-subtractor
//               with a running accumulator and valid/ready handshakes.
//               Optional clamping: ADD_SUB_ACC_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module add_sub_accumulator #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [N-1:0]     acc,
    output logic [CNT_W-1:0] op_count
);

    logic             r_out_valid;
    logic [N-1:0]     r_out_sum;
    logic             r_out_carry;
    logic             r_out_ovf;
    logic             r_out_zero;
    logic [N-1:0]     r_acc;
    logic [CNT_W-1:0] r_op_count;

    logic             w_accept;
    logic             w_sub;
    logic [N-1:0]     w_op_a;
    logic [N-1:0]     w_op_b;
    logic [N-1:0]     w_sum_raw;
    logic             w_ripple_c;
    logic             w_carry_out;
    logic             w_ovf;
    logic [N-1:0]     w_result;
    logic             w_zero;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Accumulator ops with a same-cycle clear use zero as the A operand.
    assign w_sub  = in_op[0];
    assign w_op_a = in_op[1] ? (acc_clr ? {N{1'b0}} : r_acc) : in_a;
    assign w_op_b = in_b ^ {N{w_sub}};

    always_comb begin
        w_sum_raw  = {N{1'b0}};
        w_ripple_c = w_sub;
        for (int i = 0; i < N; i++) begin
            w_sum_raw[i] = w_op_a[i] ^ w_op_b[i] ^ w_ripple_c;
            w_ripple_c   = (w_op_a[i] & w_op_b[i]) |
                           (w_ripple_c & (w_op_a[i] ^ w_op_b[i]));
        end
        w_carry_out = w_ripple_c;
    end

    assign w_ovf = (w_op_a[N-1] == w_op_b[N-1]) && (w_sum_raw[N-1] != w_op_a[N-1]);

`ifdef ADD_SUB_ACC_SATURATE_EN
    localparam logic [N-1:0] c_SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] c_SAT_MIN = {1'b1, {(N-1){1'b0}}};

    // Overflow direction follows the sign shared by both operands.
    assign w_result = w_ovf ? (w_op_a[N-1] ? c_SAT_MIN : c_SAT_MAX) : w_sum_raw;
`else
    assign w_result = w_sum_raw;
`endif

    assign w_zero = (w_result == {N{1'b0}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= {N{1'b0}};
            r_out_carry <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_zero  <= 1'b1;
            r_acc       <= {N{1'b0}};
            r_op_count  <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_result;
            r_out_carry <= w_carry_out;
            r_out_ovf   <= w_ovf;
            r_out_zero  <= w_zero;
            r_acc       <= w_result;
            r_op_count  <= r_op_count + CNT_W'(1);
        end else begin
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (acc_clr) begin
                r_acc <= {N{1'b0}};
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_carry = r_out_carry;
    assign out_ovf   = r_out_ovf;
    assign out_zero  = r_out_zero;
    assign acc       = r_acc;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_add_sub_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_sub_accumulator
// Description : Directed bench for add_sub_accumulator with an integer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_sub_accumulator;

    localparam int N     = 8;
    localparam int CNT_W = 8;
    localparam int c_MOD = 1 << N;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic             out_carry;
    logic             out_ovf;
    logic             out_zero;
    logic [N-1:0]     acc;
    logic [CNT_W-1:0] op_count;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    logic             m_valid;
    logic [N-1:0]     m_sum;
    logic             m_carry;
    logic             m_ovf;
    logic             m_zero;
    logic [N-1:0]     m_acc;
    logic [CNT_W-1:0] m_cnt;

    add_sub_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .acc       (acc),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Integer-arithmetic model of one accepted command.
    always @(posedge clk) begin
        int a, b, sa, sb, sr, u;
        logic c, o;
        logic [N-1:0] s;
        if (!rst_n) begin
            m_valid <= 1'b0; m_sum <= '0; m_carry <= 1'b0; m_ovf <= 1'b0;
            m_zero  <= 1'b1; m_acc <= '0; m_cnt   <= '0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            a  = in_op[1] ? (acc_clr ? 0 : int'(m_acc)) : int'(in_a);
            b  = int'(in_b);
            sa = (a >= c_MOD / 2) ? a - c_MOD : a;
            sb = (b >= c_MOD / 2) ? b - c_MOD : b;
            if (in_op[0]) begin
                u = a - b; c = (a >= b); sr = sa - sb;
            end else begin
                u = a + b; c = (u >= c_MOD); sr = sa + sb;
            end
            o = (sr > c_MOD / 2 - 1) || (sr < -(c_MOD / 2));
            s = N'((u + c_MOD) % c_MOD);
`ifdef ADD_SUB_ACC_SATURATE_EN
            if (o) s = (sr > 0) ? N'(c_MOD / 2 - 1) : N'(c_MOD / 2);
`endif
            m_valid <= 1'b1; m_sum <= s; m_carry <= c; m_ovf <= o;
            m_zero  <= (s == '0); m_acc <= s; m_cnt <= m_cnt + 1'b1;
        end else begin
            if (out_ready) m_valid <= 1'b0;
            if (acc_clr)   m_acc   <= '0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
            check("cyc_in_ready",  32'(in_ready),  32'(!m_valid || out_ready));
            check("cyc_out_sum",   32'(out_sum),   32'(m_sum));
            check("cyc_out_carry", 32'(out_carry), 32'(m_carry));
            check("cyc_out_ovf",   32'(out_ovf),   32'(m_ovf));
            check("cyc_out_zero",  32'(out_zero),  32'(m_zero));
            check("cyc_acc",       32'(acc),       32'(m_acc));
            check("cyc_op_count",  32'(op_count),  32'(m_cnt));
        end
    end

    task automatic cmd(input logic [1:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic clr);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; acc_clr = clr;
        @(posedge clk); #1;
        in_valid = 1'b0; acc_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        acc_clr = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; chk_en = 1'b1;
        @(posedge clk); #1;
        check("idle_valid", 32'(out_valid), 32'h0);
        check("idle_acc",   32'(acc),       32'h0);
        check("idle_cnt",   32'(op_count),  32'h0);
        check("idle_zero",  32'(out_zero),  32'h1);
        check("idle_ready", 32'(in_ready),  32'h1);

        out_ready = 1'b1;
        cmd(2'b00, 8'h05, 8'h03, 1'b0);
        check("add_sum",   32'(out_sum),   32'h08);
        check("add_carry", 32'(out_carry), 32'h0);
        check("add_ovf",   32'(out_ovf),   32'h0);
        check("add_acc",   32'(acc),       32'h08);
        check("add_cnt",   32'(op_count),  32'h1);

        cmd(2'b01, 8'h03, 8'h05, 1'b0);
        check("sub_sum",   32'(out_sum),   32'hFE);
        check("sub_carry", 32'(out_carry), 32'h0);
        check("sub_ovf",   32'(out_ovf),   32'h0);

        cmd(2'b11, 8'h00, 8'hFE, 1'b0);
        check("accsub_sum",   32'(out_sum),   32'h00);
        check("accsub_zero",  32'(out_zero),  32'h1);
        check("accsub_carry", 32'(out_carry), 32'h1);

        cmd(2'b00, 8'h7F, 8'h01, 1'b0);
        check("povf_ovf", 32'(out_ovf), 32'h1);
`ifdef ADD_SUB_ACC_SATURATE_EN
        check("povf_sum", 32'(out_sum), 32'h7F);
        check("povf_acc", 32'(acc),     32'h7F);
`else
        check("povf_sum", 32'(out_sum), 32'h80);
        check("povf_acc", 32'(acc),     32'h80);
`endif

        cmd(2'b01, 8'h80, 8'h01, 1'b0);
        check("novf_ovf",   32'(out_ovf),   32'h1);
        check("novf_carry", 32'(out_carry), 32'h1);
`ifdef ADD_SUB_ACC_SATURATE_EN
        check("novf_sum", 32'(out_sum), 32'h80);
`else
        check("novf_sum", 32'(out_sum), 32'h7F);
`endif

        @(posedge clk); #1;
        check("drain_valid", 32'(out_valid), 32'h0);

        // Back-pressure: one result held while a second command waits.
        out_ready = 1'b0;
        cmd(2'b00, 8'h10, 8'h20, 1'b0);
        check("bp_first_sum", 32'(out_sum), 32'h30);
        in_valid = 1'b1; in_op = 2'b01; in_a = 8'h50; in_b = 8'h10;
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_ready", 32'(in_ready), 32'h0);
            @(posedge clk); #1;
            check("bp_hold_sum", 32'(out_sum),  32'h30);
            check("bp_hold_cnt", 32'(op_count), 32'h6);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_second_sum", 32'(out_sum), 32'h40);
        in_op = 2'b00; in_a = 8'h01; in_b = 8'h02;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_third_sum", 32'(out_sum),  32'h03);
        check("bp_cnt",       32'(op_count), 32'h8);

        cmd(2'b00, 8'h10, 8'h00, 1'b0);
        check("clr_pre_acc", 32'(acc), 32'h10);
        cmd(2'b10, 8'hAA, 8'h04, 1'b1);
        check("clr_op_sum", 32'(out_sum), 32'h04);
        check("clr_op_acc", 32'(acc),     32'h04);
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        check("clr_only_acc", 32'(acc),     32'h00);
        check("clr_only_sum", 32'(out_sum), 32'h04);

        out_ready = 1'b0;
        cmd(2'b00, 8'h22, 8'h11, 1'b0);
        check("rst_pre_valid", 32'(out_valid), 32'h1);
        rst_n = 1'b0; in_valid = 1'b1; in_op = 2'b00; in_a = 8'h01; in_b = 8'h01;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_acc",   32'(acc),       32'h0);
        check("rst_cnt",   32'(op_count),  32'h0);
        check("rst_zero",  32'(out_zero),  32'h1);

        // Counter wrap under continuous flow with mixed commands.
        out_ready = 1'b1;
        for (int k = 0; k < 260; k++) begin
            in_valid = 1'b1;
            in_op    = 2'($urandom_range(0, 3));
            in_a     = N'($urandom);
            in_b     = N'($urandom);
            acc_clr  = ($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; acc_clr = 1'b0;
        check("wrap_cnt", 32'(op_count), 32'h4);

        repeat (3) @(posedge clk);
        #1 chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
